// File: rtl/div_16_seq.sv
// div_16_seq: sequential unsigned 16-bit restoring divider.
//
// Accepts a request whenever it is not iterating, runs one restoring step per
// clock, and publishes quotient/remainder with a one-cycle done pulse
// WIDTH edges after the accepting edge. A zero divisor skips the iteration and
// completes on the accepting edge with quotient all-ones and remainder equal to
// the dividend.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request; taken only when busy is low (idle or done state)
//   dividend     unsigned dividend, sampled on the accepting edge
//   divisor      unsigned divisor, sampled on the accepting edge
//   busy         high while iterating
//   done         one-cycle pulse marking fresh results
//   quotient     unsigned quotient of the last completed operation
//   remainder    unsigned remainder of the last completed operation
//   div_by_zero  last completed operation had a zero divisor
module div_16_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned   CntW     = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Iteration counter; the step taken while cnt_q == LastIter is the final one.
  logic [CntW-1:0] cnt_q, cnt_d;

  // Partial remainder carries one extra bit so the shifted value never
  // overflows before comparison, even for divisors with the MSB set.
  logic [WIDTH:0] rem_q, rem_d;

  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after WIDTH steps this register holds the quotient.
  logic [WIDTH-1:0] shreg_q, shreg_d;

  logic [WIDTH-1:0] dsr_q, dsr_d;

  // Published results, held until the next completed operation.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

  // Single restoring step.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic [WIDTH:0]   dsr_ext;
  logic             q_bit;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] shreg_step;

  logic accept;

  always_comb begin
    dsr_ext    = {1'b0, dsr_q};
    // Shift left discards the (always zero) top bit of the stored remainder.
    rem_shift  = (rem_q << 1) | {{WIDTH{1'b0}}, shreg_q[WIDTH-1]};
    rem_sub    = rem_shift - dsr_ext;
    q_bit      = (rem_shift >= dsr_ext);
    rem_step   = q_bit ? rem_sub : rem_shift;
    shreg_step = {shreg_q[WIDTH-2:0], q_bit};
  end

  // Requests are only honoured outside the iteration.
  assign accept = start && (state_q != StRun);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    shreg_d = shreg_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          if (divisor == '0) begin
            // Complete immediately; iteration state is left untouched.
            quo_d   = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            shreg_d = dividend;
            dsr_d   = divisor;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = StRun;
          end
        end
      end

      StRun: begin
        rem_d   = rem_step;
        shreg_d = shreg_step;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          quo_d   = shreg_step;
          rmd_d   = rem_step[WIDTH-1:0];
          dbz_d   = 1'b0;
          state_d = StDone;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      shreg_q <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      shreg_q <= shreg_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  // Status is a pure decode of the state, so it clears with reset immediately.
  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule
